// File: rtl/alu_arbiter_ctrl.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Accepts one command at a time, holds the ALU inputs from latched registers and returns one response.
module alu_arbiter_ctrl #(
  parameter int NREQ = 2,
  parameter int W    = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [2:0]   req0_opcode,
  input  logic [2:0]   req1_opcode,
  input  logic [W-1:0] req0_op1,
  input  logic [W-1:0] req0_op2,
  input  logic [W-1:0] req1_op1,
  input  logic [W-1:0] req1_op2,
  output logic [2:0]   alu_opcode,
  output logic [W-1:0] alu_op1,
  output logic [W-1:0] alu_op2,
  input  logic [W-1:0] alu_result,
  input  logic         alu_flag_c,
  input  logic         alu_flag_z,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic         rsp_flag_c,
  output logic         rsp_flag_z,
  output logic         rsp_err,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state_reg, state_next;

  logic [NREQ-1:0] valid_vec;
  logic [NREQ-1:0] grant_vec;
  logic [NREQ-1:0] ready_vec;
  logic [2:0]      opcode_arr [NREQ];
  logic [W-1:0]    op1_arr    [NREQ];
  logic [W-1:0]    op2_arr    [NREQ];

  logic            grant_id;
  logic            accept;
  logic            last_grant_reg;
  logic            exec_cnt_reg;
  logic            id_reg;
  logic            illegal_reg;
  logic [2:0]      opcode_reg;
  logic [W-1:0]    op1_reg;
  logic [W-1:0]    op2_reg;
  logic            rsp_id_reg;
  logic [W-1:0]    rsp_result_reg;
  logic            rsp_flag_c_reg;
  logic            rsp_flag_z_reg;
  logic            rsp_err_reg;

  logic [2:0]      sel_opcode;
  logic [W-1:0]    sel_op1;
  logic [W-1:0]    sel_op2;

  assign valid_vec[0]  = req0_valid;
  assign valid_vec[1]  = req1_valid;
  assign opcode_arr[0] = req0_opcode;
  assign opcode_arr[1] = req1_opcode;
  assign op1_arr[0]    = req0_op1;
  assign op1_arr[1]    = req1_op1;
  assign op2_arr[0]    = req0_op2;
  assign op2_arr[1]    = req1_op2;

  // Contention goes to whoever was not served last; otherwise the lone requester wins.
  always_comb begin
    if (valid_vec[0] && valid_vec[1]) begin
      grant_id = ~last_grant_reg;
    end else begin
      grant_id = valid_vec[1];
    end
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign grant_vec[gi] = (grant_id == 1'(gi));
      assign ready_vec[gi] = (state_reg == IDLE) && !rst && valid_vec[gi] && grant_vec[gi];
    end
  endgenerate

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];
  assign accept     = |ready_vec;

  assign sel_opcode = opcode_arr[grant_id];
  assign sel_op1    = op1_arr[grant_id];
  assign sel_op2    = op2_arr[grant_id];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // EXEC spans two cycles: a full cycle for the external ALU path, then the capture edge.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)       state_next = EXEC;
      EXEC:    if (exec_cnt_reg) state_next = RESP;
      RESP:    if (rsp_ready)    state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = (state_reg == RESP);
    busy      = (state_reg != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
      exec_cnt_reg   <= 1'b0;
      id_reg         <= 1'b0;
      illegal_reg    <= 1'b0;
      opcode_reg     <= 3'b000;
      op1_reg        <= '0;
      op2_reg        <= '0;
      rsp_id_reg     <= 1'b0;
      rsp_result_reg <= '0;
      rsp_flag_c_reg <= 1'b0;
      rsp_flag_z_reg <= 1'b0;
      rsp_err_reg    <= 1'b0;
    end else begin
      if (accept) begin
        id_reg         <= grant_id;
        last_grant_reg <= grant_id;
        exec_cnt_reg   <= 1'b0;
        // Undefined opcodes present a harmless AND of zeros to the ALU.
        if (sel_opcode > 3'd4) begin
          illegal_reg <= 1'b1;
          opcode_reg  <= 3'b000;
          op1_reg     <= '0;
          op2_reg     <= '0;
        end else begin
          illegal_reg <= 1'b0;
          opcode_reg  <= sel_opcode;
          op1_reg     <= sel_op1;
          op2_reg     <= sel_op2;
        end
      end
      if (state_reg == EXEC) begin
        exec_cnt_reg <= 1'b1;
        if (exec_cnt_reg) begin
          rsp_id_reg <= id_reg;
          rsp_err_reg <= illegal_reg;
          if (illegal_reg) begin
            rsp_result_reg <= '0;
            rsp_flag_c_reg <= 1'b0;
            rsp_flag_z_reg <= 1'b0;
          end else begin
            rsp_result_reg <= alu_result;
            rsp_flag_c_reg <= alu_flag_c;
            rsp_flag_z_reg <= alu_flag_z;
          end
        end
      end
    end
  end

  assign alu_opcode = opcode_reg;
  assign alu_op1    = op1_reg;
  assign alu_op2    = op2_reg;
  assign rsp_id     = rsp_id_reg;
  assign rsp_result = rsp_result_reg;
  assign rsp_flag_c = rsp_flag_c_reg;
  assign rsp_flag_z = rsp_flag_z_reg;
  assign rsp_err    = rsp_err_reg;

endmodule

// File: doc/alu_arbiter_ctrl.md
ALU_ARBITER_CTRL -- requirements
Module: alu_arbiter_ctrl

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters (fixed at 2 for this revision).
REQ-002 SHALL have parameter W, default 32, operand/result width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports req0_valid/req1_valid  input  1 each  requester k has a command.
REQ-006 SHALL have ports req0_ready/req1_ready  output  1 each  command accepted when valid&ready at edge.
REQ-007 SHALL have ports req0_opcode/req1_opcode  input  3 each  000 AND, 001 OR, 010 ADD, 011 SUB, 100 COMP.
REQ-008 SHALL have ports req0_op1/req0_op2/req1_op1/req1_op2  input  W each  operands.
REQ-009 SHALL have ports alu_opcode output 3, alu_op1 output W, alu_op2 output W  drive to the shared combinational ALU.
REQ-010 SHALL have ports alu_result input W, alu_flag_c input 1, alu_flag_z input 1  returned by the ALU.
REQ-011 SHALL have ports rsp_valid output 1, rsp_ready input 1, rsp_id output 1 (granted requester), rsp_result output W, rsp_flag_c output 1, rsp_flag_z output 1, rsp_err output 1.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM with states IDLE, EXEC, RESP.
REQ-014 In IDLE, SHALL assert ready only to the single requester selected by arbitration; other ready low; both low outside IDLE.
REQ-015 Arbitration SHALL be round-robin: one valid -> grant it; both valid -> grant requester other than last_grant.
REQ-016 On accept edge SHALL latch opcode, op1, op2 and grant id into internal registers, set last_grant = id, go to EXEC.
REQ-017 alu_opcode/alu_op1/alu_op2 SHALL be driven only from latched registers; they SHALL hold value in all states (no combinational path from req inputs).
REQ-018 Latched opcode 101-111 SHALL be forced to alu_opcode 000 with operands 0 and flagged as illegal.
REQ-019 At the edge ending EXEC SHALL capture alu_result, alu_flag_c, alu_flag_z into rsp_result/rsp_flag_c/rsp_flag_z, go to RESP.
REQ-020 For an illegal opcode SHALL capture rsp_result=0, rsp_flag_c=0, rsp_flag_z=0, rsp_err=1; otherwise rsp_err=0.
REQ-021 In RESP SHALL assert rsp_valid with rsp_id, result, flags, err stable until rsp_valid&rsp_ready at an edge, then go to IDLE.
REQ-022 Latency: accept at edge N -> rsp_valid high after edge N+2; earliest next accept at edge after response handshake plus one IDLE cycle.
REQ-023 rsp_ready held low SHALL stall indefinitely in RESP with all rsp_* outputs unchanged; new req_valid ignored (ready low).
REQ-024 Requester dropping valid while not ready SHALL have no effect; command contents not sampled until accept edge.
REQ-025 busy SHALL be low in IDLE and high in EXEC and RESP.

Reset
REQ-026 On rst high at an edge SHALL enter IDLE regardless of state; in-flight operation discarded, no response issued.
REQ-027 Reset values: rsp_valid 0, rsp_id 0, rsp_result 0, rsp_flag_c 0, rsp_flag_z 0, rsp_err 0, busy 0, alu_opcode 000, alu_op1 0, alu_op2 0, req ready outputs low during reset cycle.
REQ-028 last_grant SHALL reset to 1 so requester 0 wins the first simultaneous request.
REQ-029 rst SHALL take priority over any simultaneous handshake on the same edge.

Verification
REQ-030 Single: req0 ADD 0x0000_0005 + 0x0000_0003, rsp_ready=1 -> rsp_valid at N+2, rsp_id=0, rsp_result=0x0000_0008, rsp_err=0.
REQ-031 Contention: req0 and req1 valid continuously after reset -> grants 0,1,0,1; req1 SUB 0x10-0x10 returns rsp_result 0, rsp_flag_z=1 (ALU model).
REQ-032 Illegal: req1 opcode 111, op1 0xFFFF_FFFF -> alu_opcode 000, alu_op1 0, response rsp_err=1, rsp_result 0, rsp_flag_c 0, rsp_flag_z 0.
REQ-033 Backpressure: rsp_ready low 5 cycles during RESP with req1 valid -> rsp_* stable, req1_ready low, busy high; accept resumes after handshake.
REQ-034 Reset mid-op: rst at EXEC edge -> next cycle IDLE, rsp_valid 0, busy 0, all outputs at reset values, no response for the dropped op.
REQ-035 COMP: req0 op1 0x2, op2 0x9 -> rsp_result 0x0000_0001; swapped operands -> 0x0000_0000, rsp_flag_z=1.
